// File: rtl/dmem_store_buffer.sv
// Store buffer between MEM and data RAM, with youngest-match load forwarding.
// Latency: store accepted at edge N drains to RAM at edge N+1 unless a load holds the port.
// Backpressure: st_ready drops when registered count reaches DEPTH; a drain that cycle does not help.
module dmem_store_buffer #(
    parameter int          DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 129600
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_fwd_data,
    output logic                     ram_we,
    output logic [31:0]              ram_address,
    output logic [31:0]              ram_wd,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     oor_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic           oor_q;

    logic           accept;
    logic           in_range;
    logic           push;
    logic           pop;
    logic [PW-1:0]  fwd_idx;

    assign st_ready = (count_q < CW'(DEPTH));
    assign accept   = st_valid && st_ready;
    assign in_range = (st_addr < MEM_WORDS);
    assign push     = accept && in_range;
    // Loads own the RAM port; the drain simply waits.
    assign pop      = !ld_valid && (count_q != '0);

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign oor_err  = oor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (accept && !in_range) begin
                oor_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: entries are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    always_comb begin
        ram_we      = 1'b0;
        ram_address = '0;
        ram_wd      = '0;
        if (ld_valid) begin
            ram_address = ld_addr;
        end else if (count_q != '0) begin
            ram_we      = 1'b1;
            ram_address = addr_q[rd_ptr];
            ram_wd      = data_q[rd_ptr];
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        fwd_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (ld_valid && vld_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                ld_hit      = 1'b1;
                ld_fwd_data = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed table-driven bench for dmem_store_buffer plus multi-cycle corner sequences.
module tb_dmem_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_wd;
    logic        empty;
    logic [2:0]  count;
    logic        oor_err;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_store_buffer #(.DEPTH(4), .MEM_WORDS(129600)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
        .ram_we(ram_we), .ram_address(ram_address), .ram_wd(ram_wd),
        .empty(empty), .count(count), .oor_err(oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        e_rdy;
        logic        e_hit;
        logic [31:0] e_fwd;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la,
                       input logic e_rdy, input logic e_hit, input logic [31:0] e_fwd,
                       input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
                       input logic [2:0] e_cnt);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_fwd = e_fwd; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] a;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_ram_we",   32'(ram_we), 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_ram_wd",   ram_wd, 0);
        chk("rst_count",    32'(count), 0);
        chk("rst_oor",      32'(oor_err), 0);
        chk("rst_ld_hit",   32'(ld_hit), 0);
        chk("rst_fwd",      ld_fwd_data, 0);
        rst_n = 1'b1;
        tick();

        // sv sa sd lv la | rdy hit fwd we addr wd cnt  (outputs seen before the edge)
        add(1, 5, 32'hAA, 0, 0,     1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,          1, 0, 0, 1, 5, 32'hAA, 1);
        add(0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0);
        add(1, 7, 1, 1, 200,        1, 0, 0, 0, 200, 0, 0);
        add(1, 7, 2, 1, 7,          1, 1, 1, 0, 7, 0, 1);
        add(0, 0, 0, 1, 7,          1, 1, 2, 0, 7, 0, 2);
        add(0, 0, 0, 1, 8,          1, 0, 0, 0, 8, 0, 2);
        add(0, 0, 0, 0, 0,          1, 0, 0, 1, 7, 1, 2);
        add(0, 0, 0, 0, 0,          1, 0, 0, 1, 7, 2, 1);
        add(0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 32'(10 + i), 32'(16'h100 + 10 + i), 1, 100, 1, 0, 0, 0, 100, 0, 3'(i));
        add(1, 14, 32'h10E, 1, 100, 0, 0, 0, 0, 100, 0, 4);
        add(0, 0, 0, 1, 12,         0, 1, 32'h10C, 0, 12, 0, 4);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, (i != 0), 0, 0, 1, 32'(10 + i), 32'(16'h100 + 10 + i), 3'(4 - i));
        add(0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0);

        foreach (tbl[r]) begin
            drive(tbl[r].sv, tbl[r].sa, tbl[r].sd, tbl[r].lv, tbl[r].la);
            #2;
            chk($sformatf("row%0d_st_ready", r), 32'(st_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("row%0d_ld_hit", r),   32'(ld_hit), 32'(tbl[r].e_hit));
            chk($sformatf("row%0d_fwd", r),      ld_fwd_data, tbl[r].e_fwd);
            chk($sformatf("row%0d_ram_we", r),   32'(ram_we), 32'(tbl[r].e_we));
            chk($sformatf("row%0d_ram_addr", r), ram_address, tbl[r].e_addr);
            chk($sformatf("row%0d_ram_wd", r),   ram_wd, tbl[r].e_wd);
            chk($sformatf("row%0d_count", r),    32'(count), 32'(tbl[r].e_cnt));
            chk($sformatf("row%0d_empty", r),    32'(empty), 32'(tbl[r].e_cnt == 0));
            tick();
        end

        // Out-of-range store is dropped and sets a sticky error.
        drive(1, 129600, 32'hBAD, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("oor_count", 32'(count), 0);
        chk("oor_empty", 32'(empty), 1);
        chk("oor_flag",  32'(oor_err), 1);
        chk("oor_no_we", 32'(ram_we), 0);
        drive(1, 129599, 32'h55, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("last_we",   32'(ram_we), 1);
        chk("last_addr", ram_address, 129599);
        chk("last_wd",   ram_wd, 32'h55);
        chk("oor_sticky1", 32'(oor_err), 1);
        tick();
        #2;
        chk("last_drained", 32'(count), 0);
        chk("oor_sticky2",  32'(oor_err), 1);
        tick();

        // Continuous push+drain at count 3; pointers wrap several times.
        for (int i = 0; i < 3; i++) begin
            a = 32'(20 + i);
            drive(1, a, a ^ 32'hD000, 1, 500);
            exp_q.push_back(a);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            a = 32'(40 + k);
            drive(1, a, a ^ 32'hD000, 0, 0);
            #2;
            chk($sformatf("ss%0d_count", k), 32'(count), 3);
            chk($sformatf("ss%0d_rdy", k),   32'(st_ready), 1);
            chk($sformatf("ss%0d_we", k),    32'(ram_we), 1);
            chk($sformatf("ss%0d_addr", k),  ram_address, exp_q[0]);
            chk($sformatf("ss%0d_wd", k),    ram_wd, exp_q[0] ^ 32'hD000);
            void'(exp_q.pop_front());
            exp_q.push_back(a);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("tail%0d_we", k),   32'(ram_we), 1);
            chk($sformatf("tail%0d_addr", k), ram_address, exp_q[0]);
            chk($sformatf("tail%0d_wd", k),   ram_wd, exp_q[0] ^ 32'hD000);
            void'(exp_q.pop_front());
            tick();
        end
        #2;
        chk("ss_empty", 32'(empty), 1);
        tick();

        // Reset in the middle of a cycle discards queued stores.
        for (int i = 0; i < 3; i++) begin
            a = 32'(60 + i);
            drive(1, a, a, 1, 600);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        chk("pre_rst_we",    32'(ram_we), 1);
        chk("pre_rst_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(ram_we), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_addr",  ram_address, 0);
        chk("mid_rst_oor",   32'(oor_err), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            chk($sformatf("post_rst%0d_we", k),    32'(ram_we), 0);
            chk($sformatf("post_rst%0d_count", k), 32'(count), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
